// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_pkg: shared state type and sizing helpers for the skewed operand feeder.
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} feeder_state_e;
  function automatic int feed_len(input int k, input int n);
    return k + n - 1;
  endfunction
  function automatic int cnt_w(input int k, input int n, input int drain_cyc);
    int m;
    m = (k + n - 1 > drain_cyc) ? k + n - 1 : drain_cyc;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// skew_lane: one delayed operand lane; emits ops[cnt-LANE] while cnt is inside its K-slot window.
module skew_lane #(
  parameter int WIDTH = 16,
  parameter int K     = 4,
  parameter int LANE  = 0,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CW-1:0]         cnt,
  input  logic                  issue_en,
  input  logic                  stall,
  input  logic [K-1:0][WIDTH-1:0] ops,
  output logic [WIDTH-1:0]      data,
  output logic                  vld
);
  logic [WIDTH-1:0] sel;
  logic             hit;
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < K; k++)
      if (32'(cnt) == 32'(LANE + k)) begin
        sel = ops[k];
        hit = 1'b1;
      end
  end
  // A stall keeps the last operand on the wire but withdraws its valid.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (stall) begin
      vld  <= 1'b0;
    end else begin
      data <= issue_en ? sel : '0;
      vld  <= issue_en & hit;
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: captures A/B on start, streams them diagonally into an NxN array, then drains.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int N         = 4,
  parameter int K         = 4,
  parameter int DRAIN_CYC = N
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stall,
  input  logic [N-1:0][K-1:0][WIDTH-1:0]  matrixA,
  input  logic [K-1:0][N-1:0][WIDTH-1:0]  matrixB,
  output logic [N-1:0][WIDTH-1:0]         row,
  output logic [N-1:0][WIDTH-1:0]         col,
  output logic [N-1:0]                    row_vld,
  output logic [N-1:0]                    col_vld,
  output logic                            acc_clr,
  output logic                            busy,
  output logic                            done
);
  localparam int FEED_LEN = feed_len(K, N);
  localparam int CW       = cnt_w(K, N, DRAIN_CYC);
  feeder_state_e                  state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           done_d, clr_d, cap, issue, frz;
  logic [N-1:0][K-1:0][WIDTH-1:0] a_q;
  logic [K-1:0][N-1:0][WIDTH-1:0] b_q;
  assign busy  = state_q != IDLE;
  assign frz   = stall & busy;
  assign issue = (state_q == FEED) & ~stall;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clr_d   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FEED;
        cnt_d   = '0;
        clr_d   = 1'b1;
        cap     = 1'b1;
      end
      FEED: if (!stall) begin
        if (cnt_q == CW'(FEED_LEN - 1)) begin
          state_d = (DRAIN_CYC == 0) ? IDLE : DRAIN;
          done_d  = DRAIN_CYC == 0;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      DRAIN: if (!stall) begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
      acc_clr <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      acc_clr <= clr_d;
      if (cap) begin
        a_q <= matrixA;
        b_q <= matrixB;
      end
    end
  genvar i, k;
  for (i = 0; i < N; i++) begin : g_lane
    logic [K-1:0][WIDTH-1:0] b_col;
    for (k = 0; k < K; k++) begin : g_bcol
      assign b_col[k] = b_q[k][i];
    end
    skew_lane #(.WIDTH(WIDTH), .K(K), .LANE(i), .CW(CW)) u_row (
      .clk(clk), .rst_n(rst_n), .cnt(cnt_q), .issue_en(issue), .stall(frz),
      .ops(a_q[i]), .data(row[i]), .vld(row_vld[i])
    );
    skew_lane #(.WIDTH(WIDTH), .K(K), .LANE(i), .CW(CW)) u_col (
      .clk(clk), .rst_n(rst_n), .cnt(cnt_q), .issue_en(issue), .stall(frz),
      .ops(b_col), .data(col[i]), .vld(col_vld[i])
    );
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: randomized jobs checked against a slice-schedule model of the feeder.
module tb_systolic_skew_feeder;
  localparam int W = 16, N = 3, K = 3, D = 3, FL = N + K - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start0 = 1'b0, stall0 = 1'b0;
  logic [N-1:0][K-1:0][W-1:0] a0 = '0, am;
  logic [K-1:0][N-1:0][W-1:0] b0 = '0, bm;
  logic [N-1:0][W-1:0] row0, col0, er, ec;
  logic [N-1:0] rv0, cv0, erv, ecv;
  logic clr0, busy0, done0;
  logic start1 = 1'b0, stall1 = 1'b0;
  logic [0:0][0:0][W-1:0] a1 = '0, b1 = '0;
  logic [0:0][W-1:0] row1, col1;
  logic [0:0] rv1, cv1;
  logic clr1, busy1, done1;
  int checks = 0, errors = 0;

  systolic_skew_feeder #(.WIDTH(W), .N(N), .K(K), .DRAIN_CYC(D)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stall(stall0), .matrixA(a0), .matrixB(b0),
    .row(row0), .col(col0), .row_vld(rv0), .col_vld(cv0), .acc_clr(clr0), .busy(busy0), .done(done0)
  );
  systolic_skew_feeder #(.WIDTH(W), .N(1), .K(1), .DRAIN_CYC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stall(stall1), .matrixA(a1), .matrixB(b1),
    .row(row1), .col(col1), .row_vld(rv1), .col_vld(cv1), .acc_clr(clr1), .busy(busy1), .done(done1)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected diagonal slice t from the matrices captured at acceptance.
  function automatic void slice(input int t);
    for (int i = 0; i < N; i++) begin
      er[i] = '0; erv[i] = 1'b0; ec[i] = '0; ecv[i] = 1'b0;
      if (t - i >= 0 && t - i < K) begin
        er[i] = am[i][t-i]; erv[i] = 1'b1;
        ec[i] = bm[t-i][i]; ecv[i] = 1'b1;
      end
    end
  endfunction

  task automatic randomize_inputs(input bit directed);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        a0[i][k] = directed ? W'(3 * i + k + 1) : W'($urandom);
        b0[k][i] = directed ? W'(10 + 3 * k + i) : W'($urandom);
      end
  endtask

  // mode: 0 no stall, 1 random stalls, 2 three-cycle stall at slice 2
  task automatic run_job(input string name, input bit directed, input int mode, input bit keep);
    int p, ns, edges;
    bit st, edone, fin;
    randomize_inputs(directed);
    am = a0; bm = b0;
    start0 = 1'b1;
    stall0 = 1'($urandom_range(0, 1));
    step;
    checks++;
    if (clr0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0 || rv0 !== '0 || cv0 !== '0) begin
      errors++;
      $display("FAIL %s accept: clr=%b busy=%b done=%b rv=%b cv=%b, want clr=1 busy=1 done=0 rv=0 cv=0",
               name, clr0, busy0, done0, rv0, cv0);
    end
    start0 = keep;
    er = '0; ec = '0;
    p = 0; ns = 0; edges = 0; fin = 1'b0;
    while (!fin && edges < 200) begin
      randomize_inputs(1'b0);
      st = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2) ? (p == 2 && ns < 3) : 1'b0;
      stall0 = st;
      step;
      edges++;
      edone = 1'b0;
      if (st) begin
        ns++;
        erv = '0; ecv = '0;
      end else begin
        if (p < FL) slice(p);
        else begin
          er = '0; ec = '0; erv = '0; ecv = '0;
        end
        edone = (p == FL + D - 1);
        p++;
      end
      checks++;
      if (row0 !== er || col0 !== ec || rv0 !== erv || cv0 !== ecv) begin
        errors++;
        $display("FAIL %s data edge %0d: row=%h col=%h rv=%b cv=%b, want row=%h col=%h rv=%b cv=%b",
                 name, edges, row0, col0, rv0, cv0, er, ec, erv, ecv);
      end
      checks++;
      if (done0 !== edone || busy0 !== !edone || clr0 !== 1'b0) begin
        errors++;
        $display("FAIL %s ctl edge %0d: done=%b busy=%b clr=%b, want done=%b busy=%b clr=0",
                 name, edges, done0, busy0, clr0, edone, !edone);
      end
      fin = edone;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d edges, want done=1", name, done0, edges);
    end
    stall0 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (row0 !== '0 || col0 !== '0 || rv0 !== '0 || cv0 !== '0 || clr0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset: row=%h col=%h rv=%b cv=%b clr=%b busy=%b done=%b, want all 0",
               row0, col0, rv0, cv0, clr0, busy0, done0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_stall;
    stall0 = 1'b1;
    repeat (3) begin
      step;
      checks++;
      if (busy0 !== 1'b0 || rv0 !== '0 || row0 !== '0 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL idle_stall: busy=%b rv=%b row=%h done=%b, want 0", busy0, rv0, row0, done0);
      end
    end
    stall0 = 1'b0;
  endtask

  task automatic test_async_reset;
    randomize_inputs(1'b0);
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    repeat (2) step;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (row0 !== '0 || col0 !== '0 || rv0 !== '0 || cv0 !== '0 || clr0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: row=%h col=%h rv=%b cv=%b clr=%b busy=%b done=%b, want all 0",
               row0, col0, rv0, cv0, clr0, busy0, done0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job("after_reset", 1'b1, 0, 1'b0);
  endtask

  task automatic test_single;
    logic [W-1:0] ea, eb;
    ea = W'($urandom); eb = W'($urandom);
    a1[0][0] = ea; b1[0][0] = eb;
    start1 = 1'b1;
    step;
    checks++;
    if (clr1 !== 1'b1 || busy1 !== 1'b1 || rv1 !== 1'b0) begin
      errors++;
      $display("FAIL single accept: clr=%b busy=%b rv=%b, want 1 1 0", clr1, busy1, rv1);
    end
    a1[0][0] = ~ea;
    step;
    checks++;
    if (row1 !== ea || col1 !== eb || rv1 !== 1'b1 || cv1 !== 1'b1 || done1 !== 1'b1 || busy1 !== 1'b0 || clr1 !== 1'b0) begin
      errors++;
      $display("FAIL single slice: row=%h col=%h rv=%b cv=%b done=%b busy=%b clr=%b, want row=%h col=%h 1 1 1 0 0",
               row1, col1, rv1, cv1, done1, busy1, clr1, ea, eb);
    end
    step;
    checks++;
    if (clr1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0 || rv1 !== 1'b0 || row1 !== '0) begin
      errors++;
      $display("FAIL single restart: clr=%b busy=%b done=%b rv=%b row=%h, want 1 1 0 0 0",
               clr1, busy1, done1, rv1, row1);
    end
    start1 = 1'b0;
    repeat (2) step;
    checks++;
    if (busy1 !== 1'b0 || rv1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL single idle: busy=%b rv=%b done=%b, want 0 0 0", busy1, rv1, done1);
    end
  endtask

  initial begin
    test_reset;
    run_job("directed", 1'b1, 0, 1'b0);
    test_idle_stall;
    run_job("stall3", 1'b1, 2, 1'b0);
    run_job("start_held", 1'b0, 0, 1'b1);
    run_job("back_to_back", 1'b0, 1, 1'b0);
    for (int r = 0; r < 8; r++) run_job("random", 1'b0, 1, r[0]);
    start0 = 1'b0;
    test_async_reset;
    test_single;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
